// File: rtl/pll_lock_monitor.sv
// Frequency/lock monitor for one ADPLL node: counts reference and feedback edges over a
// programmable fabric-clock window. Define PLL_LOCK_MONITOR_PHASE_EN to build the phase meter.
module pll_lock_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int WINDOW_WIDTH = 12,
    parameter int CNT_WIDTH    = 10,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    ref_i,
    input  logic                    fb_i,
    input  logic [WINDOW_WIDTH-1:0] window_i,
    input  logic [3:0]              tol_i,
    output logic [CNT_WIDTH-1:0]    ref_count_o,
    output logic [CNT_WIDTH-1:0]    fb_count_o,
    output logic [CNT_WIDTH:0]      freq_err_o,
    output logic                    valid_o,
    output logic                    locked_o,
    output logic                    lost_o,
    output logic [WINDOW_WIDTH-1:0] phase_o
);

    localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EVAL    = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        if (en && (v != {CNT_WIDTH{1'b1}})) return v + CNT_WIDTH'(1'b1);
        else return v;
    endfunction

    function automatic logic [WINDOW_WIDTH-1:0] win_len(input logic [WINDOW_WIDTH-1:0] w);
        if (w == {WINDOW_WIDTH{1'b0}}) return WINDOW_WIDTH'(1'b1);
        else return w;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [SYNC_N-1:0]     ref_sync_r, fb_sync_r;
    logic                  ref_dly_r, fb_dly_r;
    logic                  ref_edge_s, fb_edge_s;
    logic [WINDOW_WIDTH-1:0] win_cnt_r, win_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]  ref_cnt_r, ref_cnt_nxt_s, fb_cnt_r, fb_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]  ref_final_s, fb_final_s;
    logic [CNT_WIDTH:0]    err_s, abs_err_s;
    logic                  in_tol_s;
    logic [STREAK_W-1:0]   streak_r, streak_nxt_s;
    logic [CNT_WIDTH-1:0]  ref_count_r, ref_count_nxt_s, fb_count_r, fb_count_nxt_s;
    logic [CNT_WIDTH:0]    freq_err_r, freq_err_nxt_s;
    logic                  valid_r, valid_nxt_s, locked_r, locked_nxt_s, lost_r, lost_nxt_s;

    // Input synchronisers plus one delay flop per input for rising-edge detection
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_sync_r <= {SYNC_N{1'b0}};
            fb_sync_r  <= {SYNC_N{1'b0}};
            ref_dly_r  <= 1'b0;
            fb_dly_r   <= 1'b0;
        end else begin
            ref_sync_r <= {ref_sync_r[SYNC_N-2:0], ref_i};
            fb_sync_r  <= {fb_sync_r[SYNC_N-2:0], fb_i};
            ref_dly_r  <= ref_sync_r[SYNC_N-1];
            fb_dly_r   <= fb_sync_r[SYNC_N-1];
        end
    end

    assign ref_edge_s = ref_sync_r[SYNC_N-1] & ~ref_dly_r;
    assign fb_edge_s  = fb_sync_r[SYNC_N-1] & ~fb_dly_r;

    // Counts including this cycle's edges: these are the window results when the window closes
    assign ref_final_s = sat_inc(ref_cnt_r, ref_edge_s);
    assign fb_final_s  = sat_inc(fb_cnt_r, fb_edge_s);
    assign err_s       = {1'b0, fb_final_s} - {1'b0, ref_final_s};
    assign abs_err_s   = err_s[CNT_WIDTH] ? (~err_s + (CNT_WIDTH+1)'(1'b1)) : err_s;
    assign in_tol_s    = (abs_err_s <= {{(CNT_WIDTH-3){1'b0}}, tol_i});

    // State, window/edge counters, results and lock status registers
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            win_cnt_r   <= {WINDOW_WIDTH{1'b0}};
            ref_cnt_r   <= {CNT_WIDTH{1'b0}};
            fb_cnt_r    <= {CNT_WIDTH{1'b0}};
            streak_r    <= {STREAK_W{1'b0}};
            ref_count_r <= {CNT_WIDTH{1'b0}};
            fb_count_r  <= {CNT_WIDTH{1'b0}};
            freq_err_r  <= {(CNT_WIDTH+1){1'b0}};
            valid_r     <= 1'b0;
            locked_r    <= 1'b0;
            lost_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            win_cnt_r   <= win_cnt_nxt_s;
            ref_cnt_r   <= ref_cnt_nxt_s;
            fb_cnt_r    <= fb_cnt_nxt_s;
            streak_r    <= streak_nxt_s;
            ref_count_r <= ref_count_nxt_s;
            fb_count_r  <= fb_count_nxt_s;
            freq_err_r  <= freq_err_nxt_s;
            valid_r     <= valid_nxt_s;
            locked_r    <= locked_nxt_s;
            lost_r      <= lost_nxt_s;
        end
    end

    // Next-state and datapath decode for the IDLE/MEASURE/EVAL sequence
    always_comb begin
        state_nxt_s     = state_r;
        win_cnt_nxt_s   = win_cnt_r;
        ref_cnt_nxt_s   = ref_cnt_r;
        fb_cnt_nxt_s    = fb_cnt_r;
        streak_nxt_s    = streak_r;
        ref_count_nxt_s = ref_count_r;
        fb_count_nxt_s  = fb_count_r;
        freq_err_nxt_s  = freq_err_r;
        valid_nxt_s     = 1'b0;
        locked_nxt_s    = locked_r;
        lost_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                ref_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                fb_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
                if (enable_i) begin
                    win_cnt_nxt_s = win_len(window_i);
                    state_nxt_s   = MEASURE;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            MEASURE: begin
                if (!enable_i) begin
                    // Abort is silent: no result, no lost pulse, lock must be re-earned
                    state_nxt_s   = IDLE;
                    ref_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                    fb_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
                    streak_nxt_s  = {STREAK_W{1'b0}};
                    locked_nxt_s  = 1'b0;
                end else if (win_cnt_r == WINDOW_WIDTH'(1'b1)) begin
                    state_nxt_s     = EVAL;
                    ref_cnt_nxt_s   = ref_final_s;
                    fb_cnt_nxt_s    = fb_final_s;
                    ref_count_nxt_s = ref_final_s;
                    fb_count_nxt_s  = fb_final_s;
                    freq_err_nxt_s  = err_s;
                    valid_nxt_s     = 1'b1;
                    if (in_tol_s) begin
                        if (streak_r != STREAK_MAX) begin
                            streak_nxt_s = streak_r + STREAK_W'(1'b1);
                        end else begin
                            streak_nxt_s = streak_r;
                        end
                        locked_nxt_s = locked_r | (streak_nxt_s == STREAK_MAX);
                    end else begin
                        streak_nxt_s = {STREAK_W{1'b0}};
                        locked_nxt_s = 1'b0;
                        lost_nxt_s   = locked_r;
                    end
                end else begin
                    ref_cnt_nxt_s = ref_final_s;
                    fb_cnt_nxt_s  = fb_final_s;
                    win_cnt_nxt_s = win_cnt_r - WINDOW_WIDTH'(1'b1);
                end
            end
            EVAL: begin
                ref_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                fb_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
                win_cnt_nxt_s = win_len(window_i);
                if (enable_i) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                ref_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                fb_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    assign ref_count_o = ref_count_r;
    assign fb_count_o  = fb_count_r;
    assign freq_err_o  = freq_err_r;
    assign valid_o     = valid_r;
    assign locked_o    = locked_r;
    assign lost_o      = lost_r;

`ifdef PLL_LOCK_MONITOR_PHASE_EN
    logic [WINDOW_WIDTH-1:0] phase_cnt_r, phase_r;

    // Phase meter: the counter holds cycles elapsed since the last ref edge, so a ref edge loads 1
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_cnt_r <= {WINDOW_WIDTH{1'b0}};
            phase_r     <= {WINDOW_WIDTH{1'b0}};
        end else if (state_r == IDLE) begin
            phase_cnt_r <= {WINDOW_WIDTH{1'b0}};
        end else if (ref_edge_s && fb_edge_s) begin
            phase_r     <= {WINDOW_WIDTH{1'b0}};
            phase_cnt_r <= WINDOW_WIDTH'(1'b1);
        end else if (ref_edge_s) begin
            phase_cnt_r <= WINDOW_WIDTH'(1'b1);
        end else begin
            if (fb_edge_s) begin
                phase_r <= phase_cnt_r;
            end
            if (phase_cnt_r != {WINDOW_WIDTH{1'b1}}) begin
                phase_cnt_r <= phase_cnt_r + WINDOW_WIDTH'(1'b1);
            end
        end
    end

    assign phase_o = phase_r;
`else
    assign phase_o = {WINDOW_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed self-checking bench for pll_lock_monitor; define PLL_LOCK_MONITOR_PHASE_EN to test phase_o.
module tb_pll_lock_monitor;

    logic        fpga_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [11:0] window   = 12'd256;
    logic [3:0]  tol      = 4'd1;
    logic        man_ref  = 1'b0;
    logic        gen_on   = 1'b0;
    logic        gen_ref  = 1'b0;
    logic        gen_fb   = 1'b0;
    logic        ref_pin, fb_pin;
    logic [9:0]  ref_count, fb_count;
    logic [10:0] freq_err;
    logic        valid, locked, lost;
    logic [11:0] phase;

    int ref_per = 8, fb_per = 8, fb_start = 0;
    int ref_ph = 0, fb_ph = 0;
    int checks = 0, errors = 0;
    int gap, vcount;

    assign ref_pin = man_ref | gen_ref;
    assign fb_pin  = gen_fb;

    pll_lock_monitor dut (
        .fpga_clk_i  (fpga_clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .ref_i       (ref_pin),
        .fb_i        (fb_pin),
        .window_i    (window),
        .tol_i       (tol),
        .ref_count_o (ref_count),
        .fb_count_o  (fb_count),
        .freq_err_o  (freq_err),
        .valid_o     (valid),
        .locked_o    (locked),
        .lost_o      (lost),
        .phase_o     (phase)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Test clock generators, stepped on the falling fabric edge; phases restart while gen_on is low
    initial begin
        forever begin
            @(negedge fpga_clk);
            if (!gen_on) begin
                ref_ph  = 0;
                fb_ph   = fb_start;
                gen_ref = 1'b0;
                gen_fb  = 1'b0;
            end else begin
                gen_ref = (ref_ph < ref_per / 2);
                gen_fb  = (fb_ph < fb_per / 2);
                ref_ph  = (ref_ph >= ref_per - 1) ? 0 : ref_ph + 1;
                fb_ph   = (fb_ph >= fb_per - 1) ? 0 : fb_ph + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] got, input logic [31:0] lo,
                             input logic [31:0] hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 1;
        @(negedge fpga_clk);
        while (valid !== 1'b1 && cycles < budget) begin
            @(negedge fpga_clk);
            cycles++;
        end
        check("valid_seen", {31'd0, valid}, 32'd1);
    endtask

    task automatic restart_gen(input int rp, input int fp, input int fs);
        gen_on = 1'b0;
        ref_per = rp;
        fb_per = fp;
        fb_start = fs;
        repeat (4) @(negedge fpga_clk);
        gen_on = 1'b1;
        repeat (20) @(negedge fpga_clk);
    endtask

    initial begin
        repeat (3) @(negedge fpga_clk);
        check("rst_ref_count", {22'd0, ref_count}, 32'd0);
        check("rst_freq_err", {21'd0, freq_err}, 32'd0);
        check("rst_flags", {29'd0, valid, locked, lost}, 32'd0);
        reset = 1'b0;

        // Matched clocks: lock on the 4th window
        restart_gen(8, 8, 0);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(400, gap);
            check("match_ref", {22'd0, ref_count}, 32'd32);
            check("match_fb", {22'd0, fb_count}, 32'd32);
            check("match_err", {21'd0, freq_err}, 32'd0);
            check("match_locked", {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Feedback speeds up to period 7: lock lost once
        fb_per = 7;
        wait_valid(400, gap);
        check("off_ref", {22'd0, ref_count}, 32'd32);
        check_rng("off_fb", {22'd0, fb_count}, 32'd36, 32'd37);
        check_rng("off_err", {21'd0, freq_err}, 32'd4, 32'd5);
        check("off_lost_pulse", {30'd0, locked, lost}, 32'd1);
        @(negedge fpga_clk);
        check("off_lost_cleared", {31'd0, lost}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            wait_valid(400, gap);
            check("off_stay_unlocked", {30'd0, locked, lost}, 32'd0);
        end
        enable = 1'b0;

        // Abort after 3 good windows; the streak must restart
        restart_gen(8, 8, 0);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wait_valid(400, gap);
            check("abort_pre_locked", {31'd0, locked}, 32'd0);
        end
        repeat (100) @(negedge fpga_clk);
        enable = 1'b0;
        vcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge fpga_clk);
            if (valid === 1'b1) vcount++;
        end
        check("abort_no_valid", vcount, 32'd0);
        check("abort_locked", {30'd0, locked, lost}, 32'd0);
        check("abort_keep_count", {22'd0, ref_count}, 32'd32);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(400, gap);
            check("relock_locked", {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of a window
        repeat (50) @(negedge fpga_clk);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check("arst_counts", {12'd0, ref_count, fb_count}, 32'd0);
        check("arst_err", {21'd0, freq_err}, 32'd0);
        check("arst_flags", {29'd0, valid, locked, lost}, 32'd0);
        @(negedge fpga_clk);
        reset = 1'b0;

        // Saturation: fb period 4 over 4095 cycles overflows a 10-bit counter
        window = 12'd4095;
        restart_gen(8, 4, 0);
        enable = 1'b1;
        wait_valid(4200, gap);
        check("sat_fb", {22'd0, fb_count}, 32'd1023);
        check_rng("sat_ref", {22'd0, ref_count}, 32'd511, 32'd512);
        check_rng("sat_err", {21'd0, freq_err}, 32'd511, 32'd512);
        enable = 1'b0;

        // Slow feedback gives a negative error
        window = 12'd256;
        restart_gen(8, 16, 0);
        enable = 1'b1;
        wait_valid(400, gap);
        check("neg_fb", {22'd0, fb_count}, 32'd16);
        check("neg_err", {21'd0, freq_err}, 32'h7F0);
        enable = 1'b0;

        // window_i=0 acts as 1; edge detected in EVAL is dropped, in final MEASURE cycle is counted
        gen_on = 1'b0;
        window = 12'd0;
        repeat (10) @(negedge fpga_clk);
        enable = 1'b1;
        wait_valid(20, gap);
        check("w0_ref_e0", {22'd0, ref_count}, 32'd0);
        man_ref = 1'b1;
        wait_valid(4, gap);
        check("w0_period", gap, 32'd2);
        check("w0_eval_edge_dropped", {22'd0, ref_count}, 32'd0);
        man_ref = 1'b0;
        wait_valid(4, gap);
        check("w0_ref_e2", {22'd0, ref_count}, 32'd0);
        @(negedge fpga_clk);
        check("w0_valid_low", {31'd0, valid}, 32'd0);
        man_ref = 1'b1;
        wait_valid(4, gap);
        check("w0_ref_e3", {22'd0, ref_count}, 32'd0);
        wait_valid(4, gap);
        check("w0_last_cycle_counted", {22'd0, ref_count}, 32'd1);
        check("w0_err_minus1", {21'd0, freq_err}, 32'h7FF);
        man_ref = 1'b0;
        enable = 1'b0;
        window = 12'd256;

`ifdef PLL_LOCK_MONITOR_PHASE_EN
        // fb lags ref by 3 fabric cycles
        restart_gen(16, 16, 13);
        enable = 1'b1;
        wait_valid(400, gap);
        check("phase_lag3", {20'd0, phase}, 32'd3);
        enable = 1'b0;
`else
        check("phase_tied_zero", {20'd0, phase}, 32'd0);
`endif

        repeat (5) @(negedge fpga_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
